// File: rtl/ram_scan_reader.sv
// ram_scan_reader: fetches one RAM word per row and drives a row-muxed LED matrix.
// Optional build macro RAM_SCAN_GNT_TIMEOUT_EN adds a 64-cycle grant timeout and gnt_miss.
module ram_scan_reader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int ROWS      = 16,
  parameter int DWELL     = 1000,
  parameter int BLANK     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              rd_req,
  input  logic              rd_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [15:0]       ram_q,
  output logic [ROWS-1:0]   row_sel,
  output logic [15:0]       col_data,
  output logic              blank,
`ifdef RAM_SCAN_GNT_TIMEOUT_EN
  output logic              gnt_miss,
`endif
  output logic              frame_done
);

  localparam int RW   = $clog2(ROWS);
  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     lat_q, lat_d;
  logic [ROWS-1:0] row_sel_q, row_sel_d;
  logic [15:0]     col_q, col_d;
  logic            fd_q, fd_d;
`ifdef RAM_SCAN_GNT_TIMEOUT_EN
  logic [5:0]      tmo_q, tmo_d;
  logic            miss_q, miss_d;
`endif

  // State, row, counters and registered matrix drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      row_sel_q <= '0;
      col_q     <= '0;
      fd_q      <= 1'b0;
`ifdef RAM_SCAN_GNT_TIMEOUT_EN
      tmo_q     <= '0;
      miss_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      row_sel_q <= row_sel_d;
      col_q     <= col_d;
      fd_q      <= fd_d;
`ifdef RAM_SCAN_GNT_TIMEOUT_EN
      tmo_q     <= tmo_d;
      miss_q    <= miss_d;
`endif
    end
  end

  // Next-state logic: fetch, blank, show, advance row; enable low aborts to IDLE.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    row_sel_d = row_sel_q;
    col_d     = col_q;
    fd_d      = 1'b0;
`ifdef RAM_SCAN_GNT_TIMEOUT_EN
    tmo_d     = tmo_q;
    miss_d    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_REQ;
          row_d   = '0;
          cnt_d   = '0;
`ifdef RAM_SCAN_GNT_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      S_REQ: begin
        if (rd_gnt) begin
          lat_d   = ram_q;
          cnt_d   = '0;
          state_d = S_BLANK;
`ifdef RAM_SCAN_GNT_TIMEOUT_EN
        end else if (tmo_q == 6'd63) begin
          lat_d   = 16'h0000;
          cnt_d   = '0;
          miss_d  = 1'b1;
          state_d = S_BLANK;
        end else begin
          tmo_d   = tmo_q + 6'd1;
`endif
        end
      end
      S_BLANK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BLANK - 1)) begin
          cnt_d     = '0;
          state_d   = S_SHOW;
          row_sel_d = ROWS'(1) << row_q;
          col_d     = lat_q;
        end
      end
      S_SHOW: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DWELL - 1)) begin
          cnt_d     = '0;
          state_d   = S_REQ;
          row_sel_d = '0;
          col_d     = '0;
`ifdef RAM_SCAN_GNT_TIMEOUT_EN
          tmo_d     = '0;
`endif
          if (row_q == RW'(ROWS - 1)) begin
            row_d = '0;
            fd_d  = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && !enable) begin
      state_d   = S_IDLE;
      row_d     = '0;
      cnt_d     = '0;
      row_sel_d = '0;
      col_d     = '0;
      fd_d      = 1'b0;
`ifdef RAM_SCAN_GNT_TIMEOUT_EN
      tmo_d     = '0;
      miss_d    = 1'b0;
`endif
    end
  end

  assign rd_req     = (state_q == S_REQ);
  assign ram_addr   = ADDR_W'(BASE_ADDR) + ADDR_W'(row_q);
  assign row_sel    = row_sel_q;
  assign col_data   = col_q;
  assign blank      = ~|row_sel_q;
  assign frame_done = fd_q;
`ifdef RAM_SCAN_GNT_TIMEOUT_EN
  assign gnt_miss   = miss_q;
`endif

endmodule

// File: tb/tb_ram_scan_reader.sv
// tb_ram_scan_reader: directed checks of ram_scan_reader with a small RAM model.
// ROWS=4, DWELL=8, BLANK=2, BASE_ADDR=10'h100.
module tb_ram_scan_reader;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        rd_req;
  logic        rd_gnt;
  logic [9:0]  ram_addr;
  logic [15:0] ram_q;
  logic [3:0]  row_sel;
  logic [15:0] col_data;
  logic        blank;
  logic        frame_done;
`ifdef RAM_SCAN_GNT_TIMEOUT_EN
  logic        gnt_miss;
`endif

  logic [15:0] mem [0:1023];
  logic [15:0] expd [4];
  int total;
  int bad;

  ram_scan_reader #(
    .ADDR_W(10), .BASE_ADDR('h100), .ROWS(4), .DWELL(8), .BLANK(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .rd_req(rd_req), .rd_gnt(rd_gnt),
    .ram_addr(ram_addr), .ram_q(ram_q),
    .row_sel(row_sel), .col_data(col_data), .blank(blank),
`ifdef RAM_SCAN_GNT_TIMEOUT_EN
    .gnt_miss(gnt_miss),
`endif
    .frame_done(frame_done)
  );

  assign ram_q = mem[ram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One scan frame; drow gets its grant dly cycles late; stops at stop_row BLANK.
  task automatic frame(input int drow, input int dly, input bit fd0,
                       input bit wr, input int stop_row);
    int lat;
    for (int r = 0; r < 4; r++) begin
      lat = (r == drow) ? dly + 1 : 1;
      for (int o = 0; o < lat + 10; o++) begin
        @(negedge clk);
        chk("rd_req", 32'(rd_req), 32'(o < lat));
        if (o < lat) chk("ram_addr", 32'(ram_addr), 32'h100 + 32'(r));
        chk("row_sel", 32'(row_sel),
            (o >= lat + 2) ? 32'(1 << r) : 32'h0);
        chk("col_data", 32'(col_data),
            (o >= lat + 2) ? 32'(expd[r]) : 32'h0);
        chk("blank", 32'(blank), 32'(o < lat + 2));
        chk("frame_done", 32'(frame_done),
            32'(r == 0 && o == 0 && fd0));
        if (r == stop_row && o == lat) begin
          enable = 1'b0;
          return;
        end
        if (wr && r == 1 && o == lat + 4) mem[10'h101] = 16'h1234;
        if (r + 1 == drow && o == lat + 9) rd_gnt = 1'b0;
        if (r == drow && o == dly) rd_gnt = 1'b1;
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    mem[10'h100] = 16'hA5A5;
    mem[10'h101] = 16'h0F0F;
    mem[10'h102] = 16'h8001;
    mem[10'h103] = 16'hFFFF;
    expd[0] = 16'hA5A5;
    expd[1] = 16'h0F0F;
    expd[2] = 16'h8001;
    expd[3] = 16'hFFFF;
    reset = 1'b1;
    enable = 1'b0;
    rd_gnt = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rd_req", 32'(rd_req), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h100);
    chk("rst_row_sel", 32'(row_sel), 32'h0);
    chk("rst_blank", 32'(blank), 32'h1);
    chk("rst_col", 32'(col_data), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);

    reset = 1'b0;
    enable = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_show_row", 32'(row_sel), 32'h1);
    chk("pre_show_col", 32'(col_data), 32'hA5A5);
    #2 reset = 1'b1;
    #1;
    chk("arst_row_sel", 32'(row_sel), 32'h0);
    chk("arst_blank", 32'(blank), 32'h1);
    chk("arst_rd_req", 32'(rd_req), 32'h0);
    chk("arst_ram_addr", 32'(ram_addr), 32'h100);
    chk("arst_col", 32'(col_data), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    frame(-1, 0, 1'b0, 1'b1, -1);
    expd[1] = 16'h1234;
    frame(2, 5, 1'b1, 1'b0, -1);
    frame(-1, 0, 1'b1, 1'b0, 3);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_rd_req", 32'(rd_req), 32'h0);
      chk("idle_row_sel", 32'(row_sel), 32'h0);
      chk("idle_blank", 32'(blank), 32'h1);
      chk("idle_fd", 32'(frame_done), 32'h0);
      chk("idle_ram_addr", 32'(ram_addr), 32'h100);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("reen_rd_req", 32'(rd_req), 32'h1);
    chk("reen_ram_addr", 32'(ram_addr), 32'h100);
    chk("reen_fd", 32'(frame_done), 32'h0);
    repeat (3) @(negedge clk);
    chk("reen_row_sel", 32'(row_sel), 32'h1);
    chk("reen_col", 32'(col_data), 32'hA5A5);

`ifdef RAM_SCAN_GNT_TIMEOUT_EN
    enable = 1'b0;
    rd_gnt = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("tmo_rd_req", 32'(rd_req), 32'h1);
      chk("tmo_miss_lo", 32'(gnt_miss), 32'h0);
    end
    @(negedge clk);
    chk("tmo_miss_hi", 32'(gnt_miss), 32'h1);
    chk("tmo_req_drop", 32'(rd_req), 32'h0);
    @(negedge clk);
    chk("tmo_miss_once", 32'(gnt_miss), 32'h0);
    @(negedge clk);
    chk("tmo_row_sel", 32'(row_sel), 32'h1);
    chk("tmo_col", 32'(col_data), 32'h0);
    repeat (8) @(negedge clk);
    chk("tmo_next_req", 32'(rd_req), 32'h1);
    chk("tmo_next_addr", 32'(ram_addr), 32'h101);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_scan_reader.md
Name: ram_scan_reader

Overview:
- Read-side master for the 16-bit board RAM. It sits opposite the CPU writer on the RAM's shared addr/we/d/q port.
- Scans ROWS consecutive words starting at BASE_ADDR, one word per display row, and drives a row-multiplexed 16-column LED matrix.
- Requests the RAM port through a req/gnt handshake with the CPU-side arbiter. Never writes the RAM.
- The RAM read is combinational: q is valid in the same cycle as addr.

Parameters:
- ADDR_W, 10, RAM word-address width.
- BASE_ADDR, 0, word address of board row 0.
- ROWS, 16, number of rows scanned per frame (2..32).
- DWELL, 1000, cycles each row is lit.
- BLANK, 16, blanking cycles before each row is lit (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scan enable.
- rd_req  out  1  RAM port request.
- rd_gnt  in  1  arbiter grant; when high, ram_addr drives the RAM and ram_q is valid this cycle.
- ram_addr  out  ADDR_W  RAM word address.
- ram_q  in  16  RAM read data.
- row_sel  out  ROWS  one-hot active row; all-zero when dark.
- col_data  out  16  column drive; bit i = column i lit.
- blank  out  1  high whenever row_sel is all-zero.
- frame_done  out  1  one-cycle pulse after the last row's dwell.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, row=0, counters=0.
  - rd_req=0, ram_addr=BASE_ADDR, row_sel=0, col_data=0, blank=1, frame_done=0.
- IDLE: all outputs at reset values. If enable=1, go to REQ on the next edge with row=0.
- REQ:
  - rd_req=1, ram_addr=BASE_ADDR+row. Address arithmetic is modulo 2^ADDR_W, so rows wrap past the top of RAM.
  - In any cycle with rd_gnt=1: latch ram_q into the row latch at that edge, drop rd_req next cycle, go to BLANK.
  - rd_gnt without rd_req is ignored.
  - A grant may arrive on the first REQ cycle, giving 1-cycle fetch latency. There is no upper bound without the optional feature.
- BLANK:
  - row_sel=0, blank=1, col_data=0, rd_req=0.
  - Runs for exactly BLANK cycles, then SHOW.
- SHOW:
  - row_sel=1<<row, blank=0, col_data=row latch.
  - Runs for exactly DWELL cycles.
  - At the end, if row==ROWS-1: row=0, frame_done=1 for one cycle (the first cycle of the next REQ). Otherwise row=row+1.
  - Then go to REQ.
- Row display period = fetch cycles + BLANK + DWELL.
- enable falling in any non-IDLE state:
  - go to IDLE at the next edge, which drops rd_req and row_sel.
  - row restarts at 0 on re-enable. No frame_done pulse.
- frame_done and the REQ entry occur in the same cycle. frame_done never asserts while enable=0.
- RAM data changed by the CPU during SHOW has no effect until that row's next fetch. A row's displayed data is always the word present on its grant cycle.
- row_sel and col_data are registered and change only on state transitions. This gives glitch-free drive.

Optional Feature:
- Macro: RAM_SCAN_GNT_TIMEOUT_EN.
- Defined:
  - A 6-bit counter runs in REQ.
  - If 64 cycles pass with no grant, drop rd_req, load the row latch with 16'h0000, pulse output gnt_miss (1 bit, reset 0) for one cycle, and proceed to BLANK.
  - That row shows dark for one period; the scan continues normally.
- Undefined: the gnt_miss port is absent, and REQ waits for rd_gnt indefinitely.

Test Plan:
- Bench parameters: ROWS=4, DWELL=8, BLANK=2, BASE_ADDR=10'h100.
- Reset then idle: reset pulse mid-SHOW, with enable=1 and rd_gnt tied to 1 -> same-cycle outputs row_sel=0, blank=1, rd_req=0, ram_addr=10'h100; the scan restarts at row 0 after reset is released.
- Full frame: RAM words 0x100..0x103 = 16'hA5A5, 16'h0F0F, 16'h8001, 16'hFFFF, immediate grant.
  - row_sel steps 0001/0010/0100/1000, each lit 8 cycles with the matching col_data and 2 dark cycles before each.
  - frame_done pulses once every 44 cycles.
- Delayed grant: rd_gnt held low 5 cycles in row 2's REQ -> rd_req stays high 5 cycles; ram_addr=10'h102 is stable throughout; the row is displayed 5 cycles later with correct data.
- Mid-dwell RAM write: CPU writes 16'h1234 to 0x101 while row 1 is lit -> col_data unchanged until row 1's next frame, then shows 16'h1234.
- Enable drop: enable=0 during row 3 BLANK -> IDLE next edge, no frame_done. Re-enable -> first fetch at ram_addr=10'h100.
- RAM_SCAN_GNT_TIMEOUT_EN defined, rd_gnt held 0 -> after 64 REQ cycles gnt_miss pulses once, row 0 is lit with col_data=0, and the scan advances to row 1.
